// File: rtl/router_pkg.sv
// Shared router definitions: port indices, port count and arbiter state encoding.
// Also provides the modulo-N_PORT wrap helper used by the round-robin logic.
package router_pkg;

    localparam int N_PORT = 5;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_W = 3'd4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Folds a value in 0..2*N_PORT-1 back into 0..N_PORT-1.
    function automatic logic [2:0] port_wrap(input logic [3:0] v);
        logic [3:0] r;
        r = (v >= 4'(N_PORT)) ? (v - 4'(N_PORT)) : v;
        return r[2:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N_PORT.
// Shared with the virtual-channel allocator.
module rr_picker
    import router_pkg::*;
(
    input  logic [N_PORT-1:0] req,
    input  logic [2:0]        ptr,
    output logic [N_PORT-1:0] winner,
    output logic [2:0]        winner_idx,
    output logic              any
);

    logic [2:0] cand_idx [N_PORT];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORT; gi++) begin : g_cand
            assign cand_idx[gi] = port_wrap(4'({1'b0, ptr}) + 4'(gi));
        end
    endgenerate

    // Lowest offset from ptr wins, so scan from the far end and let nearer hits overwrite.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int k = N_PORT - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                winner                = '0;
                winner[cand_idx[k]]   = 1'b1;
                winner_idx            = cand_idx[k];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held for a whole packet, stalled by downstream full.
// Optional stall watchdog enabled by defining OUTARB_WATCHDOG_EN.
module output_port_arbiter
    import router_pkg::*;
#(
    parameter int PKT_LEN  = 4,
    parameter int WD_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PORT-1:0] req,
    input  logic              full,
    output logic [N_PORT-1:0] grant,
    output logic [2:0]        sel,
    output logic              out_val,
    output logic              tail,
    output logic              locked,
    output logic              wd_abort
);

    arb_state_t        state_reg, state_next;
    logic [N_PORT-1:0] grant_reg, grant_next;
    logic [2:0]        sel_reg, sel_next;
    logic [2:0]        ptr_reg, ptr_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              wd_fire;

    logic [N_PORT-1:0] pick_winner;
    logic [2:0]        pick_idx;
    logic              pick_any;

    rr_picker u_picker (
        .req        (req),
        .ptr        (ptr_reg),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign locked  = (state_reg == ARB_LOCK);
    assign grant   = grant_reg;
    assign sel     = sel_reg;
    assign out_val = locked && req[sel_reg] && !full;
    assign tail    = out_val && (cnt_reg == 8'(PKT_LEN - 1));

`ifdef OUTARB_WATCHDOG_EN
    logic [7:0] stall_reg, stall_next;
    logic       wd_abort_reg;

    // Counts consecutive LOCK cycles without a transfer; fires on the WD_LIMIT-th one.
    always_comb begin
        stall_next = '0;
        wd_fire    = 1'b0;
        if (locked && !out_val) begin
            if (stall_reg == 8'(WD_LIMIT - 1)) begin
                wd_fire = 1'b1;
            end else begin
                stall_next = stall_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg    <= '0;
            wd_abort_reg <= 1'b0;
        end else begin
            stall_reg    <= stall_next;
            wd_abort_reg <= wd_fire;
        end
    end

    assign wd_abort = wd_abort_reg;
`else
    assign wd_fire  = 1'b0;
    assign wd_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ARB_IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next = ARB_LOCK;
                    grant_next = pick_winner;
                    sel_next   = pick_idx;
                    cnt_next   = '0;
                end
            end
            ARB_LOCK: begin
                if (out_val) begin
                    cnt_next = cnt_reg + 8'd1;
                end
                // Release always passes through IDLE, giving the one-cycle bubble.
                if (tail || wd_fire) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    sel_next   = '0;
                    cnt_next   = '0;
                    ptr_next   = port_wrap({1'b0, sel_reg} + 4'd1);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: vector table for reset, round robin, backpressure and
// wormhole hold, plus hand sequences for mid-packet reset and the stall watchdog.
module tb_output_port_arbiter;
    import router_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req = '0;
    logic       full = 1'b0;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       out_val, tail, locked, wd_abort;

    int checks = 0;
    int errors = 0;

    output_port_arbiter #(.PKT_LEN(4), .WD_LIMIT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .full     (full),
        .grant    (grant),
        .sel      (sel),
        .out_val  (out_val),
        .tail     (tail),
        .locked   (locked),
        .wd_abort (wd_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] req;
        logic       full;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       val;
        logic       tail;
        logic       locked;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic [4:0] rq, logic f,
                                logic [4:0] g, logic [2:0] s, logic v, logic t, logic l);
        vec_t e;
        e.name = name; e.rst = r; e.req = rq; e.full = f;
        e.grant = g; e.sel = s; e.val = v; e.tail = t; e.locked = l;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag, logic [4:0] g, logic [2:0] s, logic v, logic t,
                                 logic l, logic wd);
        check({tag, ".grant"},    32'(grant),    32'(g));
        check({tag, ".sel"},      32'(sel),      32'(s));
        check({tag, ".out_val"},  32'(out_val),  32'(v));
        check({tag, ".tail"},     32'(tail),     32'(t));
        check({tag, ".locked"},   32'(locked),   32'(l));
        check({tag, ".wd_abort"}, 32'(wd_abort), 32'(wd));
    endtask

    initial begin
        logic [4:0] oh;
        // T1 + T2: reset with all requesting, then L,N,E,S,W,L packets of 4 flits with a bubble each.
        vecs.push_back(mk("t1_rst",   1'b0, 5'b11111, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        for (int p = 0; p < 6; p++) begin
            oh = 5'b00001 << (p % 5);
            vecs.push_back(mk($sformatf("t2_idle%0d", p), 1'b1, 5'b11111, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
            for (int f = 0; f < 4; f++)
                vecs.push_back(mk($sformatf("t2_p%0d_f%0d", p, f), 1'b1, 5'b11111, 1'b0,
                                  oh, 3'(p % 5), 1, (f == 3), 1));
        end
        // T3: owner E, three full cycles after the second flit.
        vecs.push_back(mk("t3_rst",   1'b0, 5'b00100, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t3_idle",  1'b1, 5'b00100, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t3_f0",    1'b1, 5'b00100, 1'b0, 5'b00100, 3'd2, 1, 0, 1));
        vecs.push_back(mk("t3_f1",    1'b1, 5'b00100, 1'b0, 5'b00100, 3'd2, 1, 0, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk($sformatf("t3_stall%0d", k), 1'b1, 5'b00100, 1'b1, 5'b00100, 3'd2, 0, 0, 1));
        vecs.push_back(mk("t3_f2",    1'b1, 5'b00100, 1'b0, 5'b00100, 3'd2, 1, 0, 1));
        vecs.push_back(mk("t3_f3",    1'b1, 5'b00100, 1'b0, 5'b00100, 3'd2, 1, 1, 1));
        vecs.push_back(mk("t3_bub",   1'b1, 5'b00000, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t3_idle2", 1'b1, 5'b00000, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        // T4: owner N drops its request for two cycles while W waits.
        vecs.push_back(mk("t4_rst",   1'b0, 5'b00000, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t4_idle",  1'b1, 5'b00010, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t4_f0",    1'b1, 5'b10010, 1'b0, 5'b00010, 3'd1, 1, 0, 1));
        vecs.push_back(mk("t4_f1",    1'b1, 5'b10010, 1'b0, 5'b00010, 3'd1, 1, 0, 1));
        vecs.push_back(mk("t4_hold0", 1'b1, 5'b10000, 1'b0, 5'b00010, 3'd1, 0, 0, 1));
        vecs.push_back(mk("t4_hold1", 1'b1, 5'b10000, 1'b0, 5'b00010, 3'd1, 0, 0, 1));
        vecs.push_back(mk("t4_f2",    1'b1, 5'b10010, 1'b0, 5'b00010, 3'd1, 1, 0, 1));
        vecs.push_back(mk("t4_f3",    1'b1, 5'b10010, 1'b0, 5'b00010, 3'd1, 1, 1, 1));
        vecs.push_back(mk("t4_bub",   1'b1, 5'b10000, 1'b0, 5'b00000, 3'd0, 0, 0, 0));
        vecs.push_back(mk("t4_w_f0",  1'b1, 5'b10000, 1'b0, 5'b10000, 3'd4, 1, 0, 1));

        next_cycle();
        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            full = vecs[i].full;
            #2;
            check_outputs(vecs[i].name, vecs[i].grant, vecs[i].sel, vecs[i].val,
                          vecs[i].tail, vecs[i].locked, 1'b0);
            $display("vec %-12s req=%b full=%b -> grant=%b sel=%0d val=%b tail=%b locked=%b",
                     vecs[i].name, req, full, grant, sel, out_val, tail, locked);
            next_cycle();
        end

        // T5: asynchronous reset after the second flit of S.
        rst = 1'b0; req = 5'b01000; full = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        #2 check_outputs("t5_f0", 5'b01000, 3'd3, 1, 0, 1, 0);
        next_cycle();
        #2 check_outputs("t5_f1", 5'b01000, 3'd3, 1, 0, 1, 0);
        next_cycle();
        rst = 1'b0;
        #1 check_outputs("t5_async", 5'b00000, 3'd0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b1; req = 5'b11000;
        #2 check_outputs("t5_idle", 5'b00000, 3'd0, 0, 0, 0, 0);
        next_cycle();
        #2 check_outputs("t5_regrant", 5'b01000, 3'd3, 1, 0, 1, 0);
        $display("seq t5 mid-packet reset: grant=%b sel=%0d", grant, sel);
        next_cycle();

        // T6: owner L stalled by full; N also requesting.
        rst = 1'b0; req = 5'b00011; full = 1'b1;
        next_cycle();
        rst = 1'b1;
        next_cycle();
`ifdef OUTARB_WATCHDOG_EN
        for (int k = 1; k <= 16; k++) begin
            #2 check_outputs($sformatf("t6_stall%0d", k), 5'b00001, 3'd0, 0, 0, 1, 0);
            next_cycle();
        end
        #2 check_outputs("t6_abort", 5'b00000, 3'd0, 0, 0, 0, 1);
        next_cycle();
        #2 check_outputs("t6_next", 5'b00010, 3'd1, 0, 0, 1, 0);
        $display("seq t6 watchdog: next grant=%b", grant);
`else
        for (int k = 1; k <= 100; k++) begin
            #2;
            check($sformatf("t6_hold%0d.grant", k), 32'(grant), 32'(5'b00001));
            check($sformatf("t6_hold%0d.wd_abort", k), 32'(wd_abort), 32'(1'b0));
            next_cycle();
        end
        $display("seq t6 no watchdog: grant=%b after 100 stalled cycles", grant);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
